mem_access_unit: RTL and testbench

- Load/store front end sitting directly upstream of the data memory in the single-cycle MIPS datapath.
- Accepts one CPU memory request at a time: lw/lh/lhu/lb/lbu/sw/sh/sb.
- Drives the data memory's word port with word-aligned addresses. Sub-word stores are done as read-modify-write.
- Returns sign/zero-extended load data and raises an error flag on misaligned or out-of-range accesses.

---
 rtl/mem_access_unit.sv | 191 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front end for the MIPS data memory: word-aligned memory port,
// read-modify-write sub-word stores, extended loads and error detection.
// Optional build macro MEM_ACCESS_PERF_EN adds saturating perf counters.
module mem_access_unit #(
    parameter int DM_BYTES = 2048,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic              dm_we,
    output logic              dm_re,
    input  logic [31:0]       dm_rdata,
`ifdef MEM_ACCESS_PERF_EN
    output logic [15:0]       perf_loads,
    output logic [15:0]       perf_stores,
    output logic [15:0]       perf_errs,
`endif
    output logic [1:0]        fsm_state
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid is a one-cycle pulse that
    // cannot be stalled.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DM_BYTES - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       word_q;

    logic              accept;
    logic              req_err;
    logic [ADDR_W:0]   span;
    logic [ADDR_W:0]   last_byte;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign accept    = req_valid && (state == IDLE);
    assign fsm_state = state;

    // The last byte of the access must be in range, computed one bit wider
    // so addresses near the top of the bus cannot wrap back into range.
    always_comb begin
        span = '0;
        case (req_size)
            2'b00:   span = (ADDR_W+1)'(0);
            2'b01:   span = (ADDR_W+1)'(1);
            default: span = (ADDR_W+1)'(3);
        endcase
        last_byte = {1'b0, req_addr} + span;
        req_err   = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                 || (last_byte > LAST_ADDR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                      state_next = RESP;
                    else if (req_write && req_size == 2'b10) state_next = WR;
                    else                              state_next = RD;
                end
            end
            RD:      state_next = write_q ? WR : RESP;
            WR:      state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            word_q     <= '0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
                err_q      <= req_err;
            end
            if (state == RD) word_q <= dm_rdata;
        end
    end

    // Big-endian lanes: byte offset 0 lives in bits [31:24].
    always_comb begin
        byte_lane = 8'h00;
        case (addr_q[1:0])
            2'd0: byte_lane = word_q[31:24];
            2'd1: byte_lane = word_q[23:16];
            2'd2: byte_lane = word_q[15:8];
            default: byte_lane = word_q[7:0];
        endcase
        half_lane = addr_q[1] ? word_q[15:0] : word_q[31:16];

        load_val = word_q;
        case (size_q)
            2'b00: load_val = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
            2'b01: load_val = {{16{~unsigned_q & half_lane[15]}}, half_lane};
            default: load_val = word_q;
        endcase

        merged = word_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0: merged[31:24] = wdata_q[7:0];
                    2'd1: merged[23:16] = wdata_q[7:0];
                    2'd2: merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) merged[15:0]  = wdata_q[15:0];
                else           merged[31:16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    // Memory controls decode purely from state so reset kills dm_we at once.
    always_comb begin
        req_ready  = (state == IDLE);
        dm_re      = (state == RD);
        dm_we      = (state == WR);
        dm_addr    = (state == RD || state == WR) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        dm_wdata   = (state == WR) ? merged : 32'h0;
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_q;
        resp_rdata = (state == RESP && !err_q && !write_q) ? load_val : 32'h0;
    end

`ifdef MEM_ACCESS_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_errs   <= '0;
        end else if (state == RESP) begin
            if (err_q) begin
                if (perf_errs != 16'hFFFF) perf_errs <= perf_errs + 16'd1;
            end else if (write_q) begin
                if (perf_stores != 16'hFFFF) perf_stores <= perf_stores + 16'd1;
            end else begin
                if (perf_loads != 16'hFFFF) perf_loads <= perf_loads + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random requests against a
// byte-array reference model of the data memory.
module tb_mem_access_unit;

    localparam int DM_BYTES = 2048;
    localparam int AW       = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_we;
    logic          dm_re;
    logic [31:0]   dm_rdata;
    logic [1:0]    fsm_state;
`ifdef MEM_ACCESS_PERF_EN
    logic [15:0]   perf_loads;
    logic [15:0]   perf_stores;
    logic [15:0]   perf_errs;
    int            exp_loads, exp_stores, exp_errs;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.DM_BYTES(DM_BYTES), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_we(dm_we), .dm_re(dm_re), .dm_rdata(dm_rdata),
`ifdef MEM_ACCESS_PERF_EN
        .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errs(perf_errs),
`endif
        .fsm_state(fsm_state)
    );

    // Environment memory: combinational read, write on rising edge.
    logic [31:0] mem [512];
    logic [7:0]  ref_mem [DM_BYTES];

    assign dm_rdata = (dm_addr < 32'(DM_BYTES)) ? mem[dm_addr[10:2]] : 32'h0;

    always @(posedge clk) begin
        if (dm_we && dm_addr < 32'(DM_BYTES)) mem[dm_addr[10:2]] = dm_wdata;
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int base;
        base = int'(a) & ~3;
        return {ref_mem[base], ref_mem[base+1], ref_mem[base+2], ref_mem[base+3]};
    endfunction

    function automatic logic ref_err(input logic [1:0] s, input logic [31:0] a);
        longint last;
        if (s == 2'b11) return 1'b1;
        if ((longint'(a) % nbytes(s)) != 0) return 1'b1;
        last = longint'(a) + longint'(nbytes(s)) - 1;
        return last > longint'(DM_BYTES - 1);
    endfunction

    task automatic do_req(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        logic        e;
        int          n, exp_lat, lat, re_cnt, we_cnt;
        logic [31:0] v, exp_wdata, got_rdata;
        logic        got_err;
        e = ref_err(s, a);
        n = nbytes(s);
        v = 32'h0;
        exp_wdata = 32'h0;
        exp_lat = e ? 1 : (!w ? 2 : (s == 2'b10 ? 2 : 3));
        if (!e && !w) begin
            for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, ref_mem[int'(a) + i]};
            if (s == 2'b00) v = (!u && v[7])  ? {24'hFFFFFF, v[7:0]}  : {24'h0, v[7:0]};
            if (s == 2'b01) v = (!u && v[15]) ? {16'hFFFF, v[15:0]}   : {16'h0, v[15:0]};
        end
        if (!e && w) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'(d >> (8 * (n - 1 - i)));
            exp_wdata = ref_word(a);
        end

        @(negedge clk);
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = w; req_size = s; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clk);
        lat = 0; re_cnt = 0; we_cnt = 0; got_rdata = 32'hX; got_err = 1'bX;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            // Keep a bogus request pending while busy: it must be ignored.
            req_write = 1'($urandom); req_size = 2'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            check("we_re_exclusive", {31'h0, dm_we & dm_re}, 32'h0);
            if (dm_re) begin
                re_cnt++;
                check("rd_addr", dm_addr, a & ~32'h3);
            end
            if (dm_we) begin
                we_cnt++;
                check("wr_addr", dm_addr, a & ~32'h3);
                check("wr_data", dm_wdata, exp_wdata);
            end
            if (resp_valid) begin
                lat = k; got_rdata = resp_rdata; got_err = resp_err;
                req_valid = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_err", {31'h0, got_err}, {31'h0, e});
        check("resp_rdata", got_rdata, v);
        check("re_cycles", 32'(re_cnt), (!e && (!w || s != 2'b10)) ? 32'd1 : 32'd0);
        check("we_cycles", 32'(we_cnt), (!e && w) ? 32'd1 : 32'd0);
        if (!e && w) check("mem_word", mem[a[10:2]], ref_word(a));
        last_rdata = got_rdata;
`ifdef MEM_ACCESS_PERF_EN
        if (e) exp_errs++;
        else if (w) exp_stores++;
        else exp_loads++;
`endif
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        int          r;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef MEM_ACCESS_PERF_EN
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
`endif
        for (int i = 0; i < DM_BYTES; i++) ref_mem[i] = 8'($urandom);
        ref_mem[64] = 8'h88; ref_mem[65] = 8'h99; ref_mem[66] = 8'hAA; ref_mem[67] = 8'hBB;
        for (int i = 0; i < 512; i++) mem[i] = ref_word(32'(4 * i));

        // Reset state
        #2;
        check("rst_req_ready",  {31'h0, req_ready},  32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err",   {31'h0, resp_err},   32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_dm_we",      {31'h0, dm_we},      32'h0);
        check("rst_dm_re",      {31'h0, dm_re},      32'h0);
        check("rst_dm_addr",    dm_addr,  32'h0);
        check("rst_dm_wdata",   dm_wdata, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed loads and stores around word 0x40
        do_req(1'b0, 2'b00, 1'b0, 32'h41, 32'h0);
        check("lb_41_value", last_rdata, 32'hFFFFFF99);
        do_req(1'b0, 2'b00, 1'b1, 32'h41, 32'h0);
        check("lbu_41_value", last_rdata, 32'h00000099);
        do_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0);
        check("lh_42_value", last_rdata, 32'hFFFFAABB);
        do_req(1'b1, 2'b01, 1'b0, 32'h42, 32'h00001234);
        check("sh_42_word", mem[16], 32'h88991234);
        do_req(1'b1, 2'b10, 1'b0, 32'h44, 32'hDEADBEEF);
        check("sw_44_word", mem[17], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        check("lw_40_value", last_rdata, 32'h88991234);

        // Error cases and range boundaries
        do_req(1'b1, 2'b10, 1'b0, 32'h43, 32'h11111111);
        do_req(1'b0, 2'b01, 1'b0, 32'h41, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0);
        do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
        do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 32'h7FF, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h7FE, 32'hCAFE);
        do_req(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0);

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            s = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'($urandom_range(2040, 2060));
            else             a = 32'($urandom_range(0, DM_BYTES - 1));
            if (r >= 5 && s != 2'b11) a = a & ~(32'(nbytes(s)) - 32'h1);
            do_req(1'($urandom), s, 1'($urandom), a, $urandom);
        end

`ifdef MEM_ACCESS_PERF_EN
        @(negedge clk);
        check("perf_loads",  {16'h0, perf_loads},  32'(exp_loads));
        check("perf_stores", {16'h0, perf_stores}, 32'(exp_stores));
        check("perf_errs",   {16'h0, perf_errs},   32'(exp_errs));
`endif

        // Reset during the WR cycle of sb 0x40: memory must be untouched
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_rd_cycle", {31'h0, dm_re}, 32'h1);
        @(negedge clk);
        check("abort_wr_cycle", {31'h0, dm_we}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we_drop", {31'h0, dm_we}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_mem", mem[16], ref_word(32'h40));
        for (int k = 0; k < 3; k++) begin
            check("abort_ready", {31'h0, req_ready}, 32'h1);
            check("abort_no_resp", {31'h0, resp_valid}, 32'h0);
            @(negedge clk);
        end
`ifdef MEM_ACCESS_PERF_EN
        check("perf_loads_rst",  {16'h0, perf_loads},  32'h0);
        check("perf_stores_rst", {16'h0, perf_stores}, 32'h0);
        check("perf_errs_rst",   {16'h0, perf_errs},   32'h0);
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
`endif

        // Unit still works after the aborted request
        do_req(1'b0, 2'b00, 1'b1, 32'h43, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, 32'h40, 32'h000000A5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
